// File: rtl/pro_pkg.sv
// pro_pkg: shared PE-array widths, result vector type and packed-word layout
`ifndef PRO_WIDTH
`define PRO_WIDTH 8
`endif
`ifndef PRO_PARALLEL
`define PRO_PARALLEL 4
`endif
package pro_pkg;
  localparam int PACK_GROUPS_DEF = 8;
  localparam int GRP_W_DEF = $clog2(PACK_GROUPS_DEF + 1);
  typedef logic signed [`PRO_PARALLEL-1:0][`PRO_WIDTH-1:0] pro_vec_t;
  typedef struct packed {
    logic [`PRO_PARALLEL*PACK_GROUPS_DEF-1:0] data;
    logic [GRP_W_DEF-1:0] groups;
  } pack_word_t;
  function automatic logic [`PRO_PARALLEL-1:0] binarize(
    input pro_vec_t v,
    input pro_vec_t t,
    input logic [`PRO_PARALLEL-1:0] f
  );
    logic [`PRO_PARALLEL-1:0] b;
    for (int i = 0; i < `PRO_PARALLEL; i++)
      b[i] = ($signed(v[i]) >= $signed(t[i])) ^ f[i];
    return b;
  endfunction
endpackage

// File: rtl/pro_bin_fifo.sv
// pro_bin_fifo: output word FIFO that accepts push and pop together even when full
module pro_bin_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic wr, rd;
  // A full FIFO still takes a word when the head leaves in the same cycle
  always_comb begin
    wr = push && (!full || pop);
    rd = pop && valid;
    valid = cnt != '0;
    full = cnt == CW'(DEPTH);
    rdata = mem[rp];
  end
  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= wdata;
        wp <= wp + AW'(1);
      end
      if (rd) rp <= rp + AW'(1);
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/pro_bin_pack.sv
// pro_bin_pack: binarizes PE results against BN thresholds and packs groups into words
`ifndef PRO_WIDTH
`define PRO_WIDTH 8
`endif
`ifndef PRO_PARALLEL
`define PRO_PARALLEL 4
`endif
module pro_bin_pack
  import pro_pkg::*;
#(
  parameter int PACK_GROUPS = PACK_GROUPS_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  pro_vec_t                                   pro_out,
  input  logic                                       pro_last,
  input  pro_vec_t                                   thr,
  input  logic [`PRO_PARALLEL-1:0]                   thr_flip,
  input  logic                                       flush,
  output logic [`PRO_PARALLEL*PACK_GROUPS-1:0]       out_data,
  output logic [$clog2(PACK_GROUPS+1)-1:0]           out_groups,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       ovf,
  input  logic                                       clr_ovf
);
  localparam int P = `PRO_PARALLEL;
  localparam int PW = P * PACK_GROUPS;
  localparam int GW = $clog2(PACK_GROUPS + 1);
  logic [P-1:0] bits;
  logic [PW-1:0] pack_q, merged;
  logic [GW-1:0] grp_cnt, cnt_next;
  logic [PW+GW-1:0] rdata;
  logic push, pop, full;
  // Merge the incoming group into the pack register; a word leaves on completion or flush
  always_comb begin
    bits = binarize(pro_out, thr, thr_flip);
    merged = pack_q;
    if (pro_last) merged[grp_cnt*P +: P] = bits;
    cnt_next = grp_cnt + GW'(pro_last);
    push = (pro_last && cnt_next == GW'(PACK_GROUPS)) || (flush && cnt_next != '0);
    pop = out_valid && out_ready;
    {out_data, out_groups} = rdata;
  end
  // Pack register and group counter clear on every push, dropped or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_q <= '0;
      grp_cnt <= '0;
    end else if (push) begin
      pack_q <= '0;
      grp_cnt <= '0;
    end else if (pro_last) begin
      pack_q <= merged;
      grp_cnt <= cnt_next;
    end
  end
  // Sticky overflow; a new drop wins over a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else if (push && full && !pop) ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end
  pro_bin_fifo #(.W(PW + GW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .wdata({merged, cnt_next}),
    .pop(pop),
    .rdata(rdata),
    .valid(out_valid),
    .full(full)
  );
endmodule
